// File: rtl/product_accumulator.sv
// ============================================================================
// Module   : product_accumulator
// Summary  : Sums frames of LEN 8-bit products; presents the sum on valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [7:0] c_LAST = 8'(LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready depends only on state and clear, never on in_valid/out_ready
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_cnt == c_LAST);
        w_sum       = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, in_prod};
        case (r_state)
            ST_ACCUM: begin
                in_ready = !clear;
                w_accept = in_valid && !clear;
                if (w_accept && w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                out_sum   <= w_sum[ACC_W-1:0];
                out_ovf   <= r_ovf | w_sum[ACC_W];
                out_valid <= 1'b1;
                r_acc     <= '0;
                r_ovf     <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
                r_cnt <= r_cnt + 8'd1;
            end
        end else if (r_state == ST_HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulate stage that sits directly downstream of the combinational 4x4 unsigned multiplier. It consumes one 8-bit product per accepted beat and sums a frame of LEN products into an ACC_W-bit accumulator. It presents the frame sum on a valid/ready output port and holds it until the consumer accepts it. Together with the multiplier it forms a multiply-accumulate (dot-product) datapath.

## Interface
- LEN, 4: products per frame; legal range 1..255.
- ACC_W, 12: accumulator and output width; legal range 8..32.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clear  input  1  synchronous frame abort; has priority over all other inputs.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  8  unsigned product from the multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed frame.
- out_ready  input  1  consumer accepts the frame.
- out_sum  output  ACC_W  frame sum modulo 2^ACC_W.
- out_ovf  output  1  sticky: some addition in the frame carried out of ACC_W bits.

## Operation
- Reset (rst_n=0, asynchronous): state ACCUM, cnt=0, acc=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0. in_ready=1 one cycle after release.
- States:
  - ACCUM: in_ready = !clear.
  - HOLD: in_ready = 0.
- Input accept: in_valid & in_ready.
- On accept in ACCUM:
  - sum = {1'b0,acc} + zero-extended in_prod, computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0]; ovf <= ovf | sum[ACC_W]; cnt <= cnt+1.
- Frame end: accept with cnt==LEN-1.
  - out_sum <= new acc; out_ovf <= new ovf; out_valid <= 1.
  - acc, ovf, cnt <= 0; state <= HOLD.
- HOLD: out_sum, out_ovf and out_valid stay stable until out_valid & out_ready. Then out_valid <= 0 and state <= ACCUM.
- out_sum and out_ovf keep their last frame value after the handshake. They are undefined to the consumer while out_valid=0.
- in_valid=0 in ACCUM: no state change, so gaps between beats are legal.
- clear=1, any state: next cycle state=ACCUM, cnt=0, acc=0, ovf=0, out_valid=0. A pending output frame is discarded, and any beat presented that cycle is not accepted (in_ready=0).
- LEN=1: every accepted beat is a full frame, so out_sum = in_prod zero-extended.
- Max-value input: 255*LEN. No overflow occurs when ACC_W ≥ ceil(log2(255*LEN+1)).

## Timing
- Output latency: out_valid rises on the edge that accepts the last beat, so it is visible the cycle after that beat.
- Minimum frame period: LEN+1 cycles (LEN accept cycles plus one HOLD cycle with out_ready=1).
- in_ready is a function of state and clear only, with no combinational path from in_valid or out_ready. out_valid, out_sum and out_ovf are registered.
- Simultaneous out_ready handshake and in_valid in HOLD: the output completes and the input is not accepted. The first beat of the next frame is accepted the following cycle.
- rst_n assertion mid-frame or in HOLD clears everything immediately. Partial sums are lost.

## Test plan
- LEN=4, ACC_W=12, back-to-back beats 225,225,225,225 with out_ready=1 -> out_valid for exactly 1 cycle, the cycle after the 4th accept, with out_sum=900 and out_ovf=0. in_ready=0 for that cycle.
- LEN=4, ACC_W=9, beats 225×4 -> out_sum=388, out_ovf=1. Next frame 1,2,3,4 -> out_sum=10, out_ovf=0, confirming ovf is cleared per frame.
- Backpressure: frame 10,20,30,40 with out_ready=0 for 5 cycles -> out_valid=1, out_sum=100 held stable and in_ready=0 throughout. Raising out_ready completes the handshake, and in_ready=1 the next cycle.
- Gapped input: beats 7,0,255,1 with in_valid low for 3 cycles between each -> out_sum=263. cnt does not advance during gaps.
- clear after 2 accepted beats (50,60), then frame 1,1,1,1 -> out_sum=4. Also, clear asserted in HOLD -> out_valid=0 the next cycle and the frame is never handshaken.
- rst_n pulsed low mid-cycle after 3 beats -> out_valid, out_sum, out_ovf=0 immediately. After release, frame 5,5,5,5 -> out_sum=20.
